pa_f_spsram_ctrl: RTL
=====================

PA_F_SPSRAM_CTRL -- requirements
Module: pa_f_spsram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, SRAM data width.
REQ-003 SHALL have port cpuclk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port cpurst_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_vld  input  1  access request valid.
REQ-006 SHALL have port req_rdy  output  1  request accepted when req_vld&req_rdy.
REQ-007 SHALL have port req_wr  input  1  1=write, 0=read.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  access address.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port req_wmask  input  DATA_WIDTH  per-bit write enable, active-high.
REQ-011 SHALL have port rsp_vld  output  1  read data valid.
REQ-012 SHALL have port rsp_rdy  input  1  read data consumed when rsp_vld&rsp_rdy.
REQ-013 SHALL have port rsp_data  output  DATA_WIDTH  read data (equals Q).
REQ-014 SHALL have port clr_req  input  1  pulse requesting full-array clear.
REQ-015 SHALL have port init_done  output  1  high once a clear has completed and no clear is in progress.
REQ-016 SHALL have ports A/CEN/GWEN/WEN/D  output  ADDR_WIDTH/1/1/DATA_WIDTH/DATA_WIDTH  SRAM pins, CEN/GWEN/WEN active-low; Q  input  DATA_WIDTH  SRAM read data.

Function
REQ-017 SHALL implement states START, CLEAR, RUN; reset state START.
REQ-018 SHALL in START drive CEN=1, GWEN=1, WEN=all1, A=0, D=0, req_rdy=0, rsp_vld=0, and move to CLEAR on the next edge.
REQ-019 SHALL in CLEAR drive CEN=0, GWEN=0, WEN=all0, D=0, A=clear counter; counter 0..2^ADDR_WIDTH-1, one address per cycle; req_rdy=0.
REQ-020 SHALL leave CLEAR for RUN on the edge writing address 2^ADDR_WIDTH-1 (clear lasts exactly 2^ADDR_WIDTH cycles), reset counter to 0, and set init_done on that edge.
REQ-021 SHALL in RUN assert req_rdy = !rsp_vld | rsp_rdy, unless a clear is pending (REQ-027).
REQ-022 SHALL on accepted request drive SRAM pins combinationally in the same cycle: CEN=0, A=req_addr, D=req_wdata; write: GWEN=0, WEN=~req_wmask; read: GWEN=1, WEN=all1.
REQ-023 SHALL drive CEN=1, GWEN=1, WEN=all1 in every RUN cycle without an accepted request; A and D are don't-care then.
REQ-024 SHALL complete writes with no response; write with req_wmask=0 is accepted and modifies no bit.
REQ-025 SHALL assert rsp_vld on the edge after an accepted read (latency 1) and hold it until rsp_vld&rsp_rdy; rsp_data=Q, stable during the hold because CEN stays high.
REQ-026 SHALL sustain one read per cycle: rsp handshake and new request acceptance in the same cycle keep rsp_vld high.
REQ-027 SHALL latch clr_req seen in RUN into a pending flag; while pending, req_rdy=0; when pending and rsp_vld=0 (or being accepted this cycle), enter CLEAR next edge, clear init_done, clear the flag.
REQ-028 SHALL ignore clr_req during START and CLEAR.
REQ-029 SHALL not let writes in the same cycle as a read response change rsp_data of that response (guaranteed by REQ-021/025 ordering).

Reset
REQ-030 SHALL on cpurst_b low asynchronously force state START, counter 0, init_done=0, rsp_vld=0, clear pending=0, outputs per REQ-018.
REQ-031 SHALL on reset mid-CLEAR or mid-read abandon the operation; a full clear restarts after release.

Verification
REQ-032 Reset release, ADDR_WIDTH=7 -> 1 START cycle, 128 CLEAR cycles A=0..127 WEN=0, init_done=1 after; reads of addr 5 return 0.
REQ-033 Write addr 9 data 0xF mask 0xF, then write data 0x0 mask 0x5, read addr 9 -> rsp_data=0xA one cycle after acceptance.
REQ-034 Back-to-back reads addr 1,2,3 with rsp_rdy=1 -> rsp_vld high 3 consecutive cycles, data in order, req_rdy never low.
REQ-035 Read with rsp_rdy=0 for 4 cycles -> req_rdy=0, CEN=1, rsp_data stable for 4 cycles, released on rsp_rdy=1.
REQ-036 clr_req while response stalled -> CLEAR starts the cycle after response accepted, init_done low 128 cycles, then array reads 0.
REQ-037 cpurst_b low at CLEAR address 60 -> outputs immediately per REQ-018; after release clear restarts at 0.

Source files
------------

// File: rtl/pa_f_spsram_ctrl.sv
// Single-port SRAM controller: clears the whole array after reset or on request,
// then serves masked writes and latency-1 reads under valid/ready handshakes.
module pa_f_spsram_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  clr_req,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q,
    output logic [1:0]            o_dbg_state
);

    // Handshakes: a request transfers on a cycle where req_vld && req_rdy; a read
    // response transfers on a cycle where rsp_vld && rsp_rdy. rsp_vld/rsp_data hold
    // until that transfer. Neither valid depends combinationally on its ready.
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_init_done;
    logic                    r_rsp_vld;
    logic                    r_clr_pend;
    logic                    w_accept;
    logic                    w_rsp_free;
    logic                    w_last;

    assign w_rsp_free  = !r_rsp_vld || rsp_rdy;
    assign w_last      = (r_cnt == {ADDR_WIDTH{1'b1}});
    assign rsp_vld     = r_rsp_vld;
    assign rsp_data    = Q;
    assign init_done   = r_init_done;
    assign o_dbg_state = r_state;

    always_comb begin
        w_next_state = r_state;
        req_rdy      = 1'b0;
        w_accept     = 1'b0;
        CEN          = 1'b1;
        GWEN         = 1'b1;
        WEN          = {DATA_WIDTH{1'b1}};
        A            = '0;
        D            = '0;
        case (r_state)
            ST_START: begin
                w_next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                CEN  = 1'b0;
                GWEN = 1'b0;
                WEN  = '0;
                A    = r_cnt;
                if (w_last) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                req_rdy  = !r_clr_pend && w_rsp_free;
                w_accept = req_vld && req_rdy;
                if (w_accept) begin
                    CEN  = 1'b0;
                    A    = req_addr;
                    D    = req_wdata;
                    GWEN = !req_wr;
                    WEN  = req_wr ? ~req_wmask : {DATA_WIDTH{1'b1}};
                end
                // A pending clear waits only for the outstanding response to drain.
                if (r_clr_pend && w_rsp_free) begin
                    w_next_state = ST_CLEAR;
                end
            end
            default: begin
                w_next_state = ST_START;
            end
        endcase
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state     <= ST_START;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_clr_pend  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (r_state == ST_CLEAR && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == ST_CLEAR && w_last) begin
                r_init_done <= 1'b1;
            end else if (r_state == ST_RUN && w_next_state == ST_CLEAR) begin
                r_init_done <= 1'b0;
            end

            if (r_state == ST_RUN) begin
                r_rsp_vld <= (w_accept && !req_wr) || (r_rsp_vld && !rsp_rdy);
            end else begin
                r_rsp_vld <= 1'b0;
            end

            if (r_state == ST_RUN && w_next_state != ST_CLEAR) begin
                r_clr_pend <= r_clr_pend || clr_req;
            end else begin
                r_clr_pend <= 1'b0;
            end
        end
    end

endmodule
